arp_table_learner: RTL and testbench

//  Writer-side companion to the ARP lookup table. Accepts learned (IP, MAC) bindings from the
//  ARP packet parser and drives the table's register-side rd/wr req/ack port to insert them.

---
 rtl/arp_table_learner_if.sv | 48 ++++
 rtl/arp_table_learner.sv | 200 ++++++++++++++++++++
 tb/tb_arp_table_learner.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_table_learner_if.sv
// ---------------------------------------------------------------------------
// arp_table_learner_if: learn-side and ARP table rd/wr req/ack signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface arp_table_learner_if #(
   parameter int ADDR_W = 5
);
   logic              learn_req;
   logic [31:0]       learn_ip;
   logic [47:0]       learn_mac;
   logic              learn_busy;
   logic              learn_done;
   logic              learn_hit;
   logic              learn_evict;
   logic              learn_err;
   logic [ADDR_W-1:0] learn_index;

   logic              table_rd_req;
   logic              table_rd_ack;
   logic [ADDR_W-1:0] table_rd_addr;
   logic [95:0]       table_rd_data;
   logic              table_wr_req;
   logic              table_wr_ack;
   logic [ADDR_W-1:0] table_wr_addr;
   logic [95:0]       table_wr_data;

   modport master (
      input  learn_req, learn_ip, learn_mac,
      output learn_busy, learn_done, learn_hit, learn_evict, learn_err, learn_index,
      output table_rd_req, table_rd_addr,
      input  table_rd_ack, table_rd_data,
      output table_wr_req, table_wr_addr, table_wr_data,
      input  table_wr_ack
   );

   modport slave (
      output learn_req, learn_ip, learn_mac,
      input  learn_busy, learn_done, learn_hit, learn_evict, learn_err, learn_index,
      input  table_rd_req, table_rd_addr,
      output table_rd_ack, table_rd_data,
      input  table_wr_req, table_wr_addr, table_wr_data,
      output table_wr_ack
   );
endinterface

`default_nettype wire

// File: rtl/arp_table_learner.sv
// ---------------------------------------------------------------------------
// arp_table_learner: scans the ARP table and inserts learned IP/MAC bindings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arp_table_learner #(
   parameter int NUM_ENTRIES = 32,
   parameter int ADDR_W      = 5,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   arp_table_learner_if.master bus
);

   localparam int                TCNT_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RD_GAP = 3'd2,
      S_WR_GAP = 3'd3,
      S_WR     = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [31:0]         ip_q, ip_n;
   logic [47:0]         mac_q, mac_n;
   logic [ADDR_W-1:0]   idx, idx_n;
   logic                free_found, free_found_n;
   logic [ADDR_W-1:0]   free_idx, free_idx_n;
   logic [ADDR_W-1:0]   target, target_n;
   logic                hit, hit_n;
   logic                evict, evict_n;
   logic                err, err_n;
   logic [ADDR_W-1:0]   repl_ptr, repl_ptr_n;
   logic [TCNT_W-1:0]   tcnt, tcnt_n;
   logic                scan_found;
   logic [ADDR_W-1:0]   scan_idx;
   logic                timed_out;
   logic                unused_rd_hi;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ip_q       <= '0;
         mac_q      <= '0;
         idx        <= '0;
         free_found <= 1'b0;
         free_idx   <= '0;
         target     <= '0;
         hit        <= 1'b0;
         evict      <= 1'b0;
         err        <= 1'b0;
         repl_ptr   <= '0;
         tcnt       <= '0;
      end else begin
         state      <= state_n;
         ip_q       <= ip_n;
         mac_q      <= mac_n;
         idx        <= idx_n;
         free_found <= free_found_n;
         free_idx   <= free_idx_n;
         target     <= target_n;
         hit        <= hit_n;
         evict      <= evict_n;
         err        <= err_n;
         repl_ptr   <= repl_ptr_n;
         tcnt       <= tcnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      ip_n         = ip_q;
      mac_n        = mac_q;
      idx_n        = idx;
      free_found_n = free_found;
      free_idx_n   = free_idx;
      target_n     = target;
      hit_n        = hit;
      evict_n      = evict;
      err_n        = err;
      repl_ptr_n   = repl_ptr;
      tcnt_n       = tcnt;
      scan_found   = free_found;
      scan_idx     = free_idx;
      timed_out    = (tcnt == TCNT_LAST);

      case (state)
         S_IDLE: begin
            if (bus.learn_req) begin
               ip_n         = bus.learn_ip;
               mac_n        = bus.learn_mac;
               idx_n        = '0;
               free_found_n = 1'b0;
               target_n     = '0;
               hit_n        = 1'b0;
               evict_n      = 1'b0;
               tcnt_n       = '0;
               // IP 0 is the empty-slot marker, so it can never be stored
               if (bus.learn_ip == 32'd0) begin
                  err_n   = 1'b1;
                  state_n = S_DONE;
               end else begin
                  err_n   = 1'b0;
                  state_n = S_RD;
               end
            end
         end

         S_RD: begin
            if (bus.table_rd_ack) begin
               tcnt_n = '0;
               if (bus.table_rd_data[31:0] == ip_q) begin
                  target_n = idx;
                  hit_n    = 1'b1;
                  state_n  = S_WR_GAP;
               end else begin
                  if (bus.table_rd_data[31:0] == 32'd0 && !free_found) begin
                     scan_found = 1'b1;
                     scan_idx   = idx;
                  end
                  free_found_n = scan_found;
                  free_idx_n   = scan_idx;
                  if (idx == LAST_IDX) begin
                     target_n = scan_found ? scan_idx : repl_ptr;
                     evict_n  = !scan_found;
                     state_n  = S_WR_GAP;
                  end else begin
                     idx_n   = idx + 1'b1;
                     state_n = S_RD_GAP;
                  end
               end
            end else if (timed_out) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end

         // Gap states give the mandatory idle cycle between requests
         S_RD_GAP: begin
            tcnt_n  = '0;
            state_n = S_RD;
         end

         S_WR_GAP: begin
            tcnt_n  = '0;
            state_n = S_WR;
         end

         S_WR: begin
            if (bus.table_wr_ack) begin
               tcnt_n = '0;
               if (evict)
                  repl_ptr_n = (repl_ptr == LAST_IDX) ? '0 : repl_ptr + 1'b1;
               state_n = S_DONE;
            end else if (timed_out) begin
               hit_n   = 1'b0;
               evict_n = 1'b0;
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end

         S_DONE: begin
            tcnt_n  = '0;
            state_n = S_IDLE;
         end

         default: state_n = S_IDLE;
      endcase
   end

   assign bus.table_rd_req  = (state == S_RD);
   assign bus.table_rd_addr = idx;
   assign bus.table_wr_req  = (state == S_WR);
   assign bus.table_wr_addr = target;
   assign bus.table_wr_data = {16'h0000, mac_q, ip_q};

   assign bus.learn_busy  = (state != S_IDLE);
   assign bus.learn_done  = (state == S_DONE);
   assign bus.learn_hit   = hit;
   assign bus.learn_evict = evict;
   assign bus.learn_err   = err;
   assign bus.learn_index = target;

   assign unused_rd_hi = ^bus.table_rd_data[95:32];

endmodule

`default_nettype wire

// File: tb/tb_arp_table_learner.sv
// ---------------------------------------------------------------------------
// tb_arp_table_learner: vector table, directed corner cases and randomized learns
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arp_table_learner;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int TO = 255;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   arp_table_learner_if #(.ADDR_W(AW)) bus ();

   arp_table_learner #(.NUM_ENTRIES(N), .ADDR_W(AW), .ACK_TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] tbl_ip  [N];
   logic [47:0] tbl_mac [N];
   logic [31:0] ref_ip  [N];
   logic [47:0] ref_mac [N];
   int          ref_repl;

   int checks = 0;
   int errors = 0;
   int reads = 0, writes = 0, dones = 0, rd_hi = 0;
   int ack_delay = 0, rd_wait = 0, wr_wait = 0;
   bit rd_stall = 1'b0, wr_stall = 1'b0;
   logic [95:0] wr_log [$];

   typedef struct {
      logic [31:0] ip;
      logic [47:0] mac;
      bit          err;
      bit          hit;
      bit          evict;
      int          idx;
      int          nreads;
   } vec_t;

   vec_t vecs [6];

   // Table side: acks after ack_delay cycles of req, serves reads and applies writes
   initial begin
      bus.table_rd_ack  = 1'b0;
      bus.table_wr_ack  = 1'b0;
      bus.table_rd_data = '0;
      forever begin
         @(negedge clk);
         if (bus.learn_done) dones++;
         if (bus.table_rd_req) begin
            rd_hi++;
            if (!rd_stall && rd_wait >= ack_delay) begin
               bus.table_rd_ack  = 1'b1;
               bus.table_rd_data = {16'h0, tbl_mac[bus.table_rd_addr], tbl_ip[bus.table_rd_addr]};
               reads++;
            end else begin
               bus.table_rd_ack = 1'b0;
               rd_wait++;
            end
         end else begin
            bus.table_rd_ack = 1'b0;
            rd_wait = 0;
         end
         if (bus.table_wr_req) begin
            if (!wr_stall && wr_wait >= ack_delay) begin
               bus.table_wr_ack = 1'b1;
               tbl_ip[bus.table_wr_addr]  = bus.table_wr_data[31:0];
               tbl_mac[bus.table_wr_addr] = bus.table_wr_data[79:32];
               wr_log.push_back(bus.table_wr_data);
               writes++;
            end else begin
               bus.table_wr_ack = 1'b0;
               wr_wait++;
            end
         end else begin
            bus.table_wr_ack = 1'b0;
            wr_wait = 0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic clear_tables();
      for (int i = 0; i < N; i++) begin
         tbl_ip[i] = '0; tbl_mac[i] = '0;
         ref_ip[i] = '0; ref_mac[i] = '0;
      end
   endtask

   task automatic check_learn(input string name, input logic [31:0] ip, input logic [47:0] mac,
                              input bit e_err, input bit e_hit, input bit e_evict,
                              input int e_idx, input int e_reads, output int lat);
      int r0, w0;
      r0 = reads;
      w0 = writes;
      @(negedge clk);
      bus.learn_req = 1'b1;
      bus.learn_ip  = ip;
      bus.learn_mac = mac;
      @(negedge clk);
      bus.learn_req = 1'b0;
      chk({name, ".busy"}, bus.learn_busy, 1'b1);
      lat = 0;
      while (!bus.learn_done && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk({name, ".done"}, bus.learn_done, 1'b1);
      chk({name, ".err"}, bus.learn_err, e_err);
      chk({name, ".hit"}, bus.learn_hit, e_hit);
      chk({name, ".evict"}, bus.learn_evict, e_evict);
      if (!e_err) chk({name, ".index"}, bus.learn_index, e_idx);
      chk({name, ".reads"}, reads - r0, e_reads);
      chk({name, ".writes"}, writes - w0, e_err ? 0 : 1);
      @(negedge clk);
      chk({name, ".pulse"}, bus.learn_done, 1'b0);
      chk({name, ".hold"}, {bus.learn_hit, bus.learn_evict, bus.learn_err}, {e_hit, e_evict, e_err});
   endtask

   initial begin
      int lat, d0, w0, h0, cnt;
      logic [31:0] ip;
      logic [47:0] mac;

      vecs[0] = '{32'h0A000001, 48'h001122334455, 1'b0, 1'b0, 1'b0, 0, 32};
      vecs[1] = '{32'h0A000002, 48'h0000000000B2, 1'b0, 1'b0, 1'b0, 1, 32};
      vecs[2] = '{32'h0A000001, 48'hAABBCCDDEEFF, 1'b0, 1'b1, 1'b0, 0, 1};
      vecs[3] = '{32'h00000000, 48'h123456789ABC, 1'b1, 1'b0, 1'b0, 0, 0};
      vecs[4] = '{32'h0A000002, 48'h000000000002, 1'b0, 1'b1, 1'b0, 1, 2};
      vecs[5] = '{32'hC0A80001, 48'h0000000000C5, 1'b0, 1'b0, 1'b0, 2, 32};

      bus.learn_req = 1'b0;
      bus.learn_ip  = '0;
      bus.learn_mac = '0;
      clear_tables();

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.busy", bus.learn_busy, 1'b0);
      chk("rst.done", bus.learn_done, 1'b0);
      chk("rst.reqs", {bus.table_rd_req, bus.table_wr_req}, 2'b00);
      chk("rst.status", {bus.learn_hit, bus.learn_evict, bus.learn_err, bus.learn_index}, '0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         check_learn($sformatf("vec%0d", i), vecs[i].ip, vecs[i].mac, vecs[i].err, vecs[i].hit,
                     vecs[i].evict, vecs[i].idx, vecs[i].nreads, lat);
         if (!vecs[i].err) chk($sformatf("vec%0d.latency_le70", i), lat <= 70, 1'b1);
         else chk($sformatf("vec%0d.err_latency", i), lat, 0);
      end
      chk("vec0.wr_data", wr_log[0], 96'h0000_001122334455_0A000001);

      // Existing IP at slot 7: scan must stop there
      clear_tables();
      for (int i = 0; i < 7; i++) tbl_ip[i] = 32'h0D000001 + i;
      tbl_ip[7] = 32'h0A0A0A0A;
      check_learn("idx7", 32'h0A0A0A0A, 48'hDEADBEEF0007, 0, 1, 0, 7, 8, lat);
      chk("idx7.mac", tbl_mac[7], 48'hDEADBEEF0007);

      // A learn_req arriving mid-scan is dropped
      clear_tables();
      d0 = dones;
      w0 = writes;
      @(negedge clk);
      bus.learn_req = 1'b1; bus.learn_ip = 32'h0A000010; bus.learn_mac = 48'h1;
      @(negedge clk);
      bus.learn_req = 1'b0;
      repeat (6) @(negedge clk);
      chk("drop.busy", bus.learn_busy, 1'b1);
      bus.learn_req = 1'b1; bus.learn_ip = 32'h0A000020; bus.learn_mac = 48'h2;
      @(negedge clk);
      bus.learn_req = 1'b0;
      cnt = 0;
      while (!bus.learn_done && cnt < 2000) begin @(negedge clk); cnt++; end
      chk("drop.done", bus.learn_done, 1'b1);
      chk("drop.index", bus.learn_index, 0);
      repeat (80) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < N; i++) if (tbl_ip[i] == 32'h0A000020) cnt++;
      chk("drop.not_written", cnt, 0);
      chk("drop.one_done", dones - d0, 1);
      chk("drop.one_write", writes - w0, 1);

      // Full table: round-robin eviction, then free-slot preference
      clear_tables();
      for (int i = 0; i < N; i++) begin tbl_ip[i] = 32'h0B000001 + i; tbl_mac[i] = 48'(i); end
      check_learn("full0", 32'h0E000001, 48'hE1, 0, 0, 1, 0, 32, lat);
      check_learn("full1", 32'h0E000002, 48'hE2, 0, 0, 1, 1, 32, lat);
      check_learn("full2", 32'h0E000003, 48'hE3, 0, 0, 1, 2, 32, lat);
      tbl_ip[4] = 32'h0;
      check_learn("free4", 32'h0E000004, 48'hE4, 0, 0, 0, 4, 32, lat);
      check_learn("repl3", 32'h0E000005, 48'hE5, 0, 0, 1, 3, 32, lat);

      // Read ack timeout must not disturb the replacement pointer
      rd_stall = 1'b1;
      h0 = rd_hi;
      check_learn("timeout", 32'h0E000006, 48'hE6, 1, 0, 0, 0, 0, lat);
      chk("timeout.req_cycles", rd_hi - h0, TO);
      rd_stall = 1'b0;
      check_learn("repl4", 32'h0E000007, 48'hE7, 0, 0, 1, 4, 32, lat);

      // Reset while the write is outstanding
      clear_tables();
      wr_stall = 1'b1;
      d0 = dones;
      w0 = writes;
      @(negedge clk);
      bus.learn_req = 1'b1; bus.learn_ip = 32'h0A000030; bus.learn_mac = 48'h30;
      @(negedge clk);
      bus.learn_req = 1'b0;
      cnt = 0;
      while (!bus.table_wr_req && cnt < 500) begin @(negedge clk); cnt++; end
      chk("rstwr.wr_req_seen", bus.table_wr_req, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstwr.wr_req_drop", bus.table_wr_req, 1'b0);
      chk("rstwr.busy", bus.learn_busy, 1'b0);
      reset = 1'b0;
      wr_stall = 1'b0;
      repeat (10) @(negedge clk);
      chk("rstwr.no_done", dones - d0, 0);
      chk("rstwr.no_write", writes - w0, 0);

      // Randomized learns against a slot-level reference model
      clear_tables();
      ref_repl = 0;
      for (int it = 0; it < 60; it++) begin
         int m, f, e_idx, e_reads;
         bit e_err, e_hit, e_ev;
         if ($urandom_range(0, 4) == 0) begin
            int k;
            k = $urandom_range(0, N - 1);
            tbl_ip[k] = '0;
            ref_ip[k] = '0;
         end
         ip  = ($urandom_range(0, 19) == 0) ? 32'h0 : 32'h0C000000 + 32'($urandom_range(1, 40));
         mac = {16'($urandom), 32'($urandom)};
         ack_delay = $urandom_range(0, 2);
         m = -1;
         f = -1;
         for (int i = N - 1; i >= 0; i--) begin
            if (ref_ip[i] == ip) m = i;
            if (ref_ip[i] == 32'h0) f = i;
         end
         e_err   = (ip == 32'h0);
         e_hit   = !e_err && (m >= 0);
         e_ev    = !e_err && (m < 0) && (f < 0);
         e_idx   = (m >= 0) ? m : (f >= 0) ? f : ref_repl;
         e_reads = e_err ? 0 : (m >= 0) ? m + 1 : N;
         check_learn($sformatf("rnd%0d", it), ip, mac, e_err, e_hit, e_ev, e_idx, e_reads, lat);
         if (!e_err) begin
            ref_ip[e_idx]  = ip;
            ref_mac[e_idx] = mac;
            if (e_ev) ref_repl = (ref_repl + 1) % N;
            chk($sformatf("rnd%0d.slot", it), {tbl_mac[e_idx], tbl_ip[e_idx]}, {mac, ip});
         end
      end
      ack_delay = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
